// File: rtl/button_pkg.sv
// Shared definitions for the button event generator: FSM state encoding and
// the default "pressed" input level.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2,
        ST_REPEAT  = 2'd3
    } state_t;

    localparam logic ACTIVE_LEVEL_DEFAULT = 1'b1;

endpackage

// File: rtl/button_event_hold_timer.sv
// Hold timer: up-counter with synchronous clear and count-enable, flagging
// when the count equals a runtime-selected terminal value.
module hold_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic [CNT_W-1:0] terminal,
    output logic             match
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    assign match = (count == terminal);

endmodule

// File: rtl/button_event.sv
// Button event generator: registered press/release/long/repeat pulses from a
// debounced level. Auto-repeat is built only with BUTTON_EVENT_REPEAT_EN.
// The release and repeat outputs are named release_pulse and repeat_pulse
// because release and repeat are reserved words.
import button_pkg::*;

module button_event #(
    parameter logic        ACTIVE_LEVEL  = ACTIVE_LEVEL_DEFAULT,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LONG_COUNT    = 50000,
    parameter int unsigned REPEAT_PERIOD = 10000
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic enable,
    input  logic in,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    state_t state_q, state_d;
    logic   prev;
    logic   press_edge, release_edge;
    logic   press_d, release_d, long_d, repeat_d;
    logic   timer_clear, timer_en, timer_match;
    logic [CNT_W-1:0] terminal;

    assign press_edge   = (in == ACTIVE_LEVEL) && (prev != ACTIVE_LEVEL);
    assign release_edge = (in != ACTIVE_LEVEL) && (prev == ACTIVE_LEVEL);
    assign terminal     = (state_q == ST_PRESSED) ? CNT_W'(LONG_COUNT - 1)
                                                  : CNT_W'(REPEAT_PERIOD - 1);

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            prev          <= ~ACTIVE_LEVEL;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev          <= in;
            press         <= press_d;
            release_pulse <= release_d;
            long_press    <= long_d;
            repeat_pulse  <= repeat_d;
            held          <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_edge) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (release_edge) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                    end else if (timer_match) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                    end
                end
                ST_LONG: begin
                    if (release_edge) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                    end else if (timer_match) begin
                        state_d  = ST_REPEAT;
                        repeat_d = 1'b1;
`endif
                    end
                end
                ST_REPEAT: begin
                    if (release_edge) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                    end else if (timer_match) begin
                        repeat_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Every event restarts the timer, so the terminal compare never sees a wrap.
        timer_clear = (state_d == ST_IDLE) || press_d || release_d || long_d || repeat_d;
`ifdef BUTTON_EVENT_REPEAT_EN
        timer_en    = !timer_clear;
`else
        timer_en    = !timer_clear && (state_d != ST_LONG);
`endif
    end

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk      (CLK),
        .reset_n  (reset_n),
        .clear    (timer_clear),
        .count_en (timer_en),
        .terminal (terminal),
        .match    (timer_match)
    );

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: a time-since-press reference model
// pushes expected output vectors that are popped and compared each cycle.
module tb_button_event;

    localparam int unsigned LONG_COUNT    = 8;
    localparam int unsigned REPEAT_PERIOD = 4;

    logic CLK = 1'b0;
    logic reset_n, enable, in;
    logic press, release_pulse, long_press, repeat_pulse, held;

    always #5 CLK = ~CLK;

    button_event #(
        .ACTIVE_LEVEL  (1'b1),
        .CNT_W         (16),
        .LONG_COUNT    (LONG_COUNT),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .enable        (enable),
        .in            (in),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Expected vector {press, release, long_press, repeat, held}
    logic [4:0] exp_q[$];

    logic        m_prev = 1'b0;
    logic        m_held = 1'b0;
    int unsigned m_age  = 0;
    string       scen   = "init";

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b (press,rel,long,rep,held) t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] model(input logic rst_n, input logic en, input logic lvl);
        logic [4:0] v;
        logic rise, fall;
        v = '0;
        if (!rst_n) begin
            m_prev = 1'b0;
            m_held = 1'b0;
            m_age  = 0;
        end else if (!en) begin
            m_prev = lvl;
            m_held = 1'b0;
            m_age  = 0;
        end else begin
            rise   = lvl && !m_prev;
            fall   = !lvl && m_prev;
            m_prev = lvl;
            if (!m_held) begin
                if (rise) begin
                    v[4]   = 1'b1;
                    m_held = 1'b1;
                    m_age  = 0;
                end
            end else begin
                m_age++;
                if (fall) begin
                    v[3]   = 1'b1;
                    m_held = 1'b0;
                end else if (m_age == LONG_COUNT) begin
                    v[2] = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                end else if (m_age > LONG_COUNT &&
                             ((m_age - LONG_COUNT) % REPEAT_PERIOD) == 0) begin
                    v[1] = 1'b1;
`endif
                end
            end
        end
        v[0] = m_held;
        return v;
    endfunction

    task automatic step(input logic rst_n, input logic en, input logic lvl);
        logic [4:0] exp;
        reset_n = rst_n;
        enable  = en;
        in      = lvl;
        exp_q.push_back(model(rst_n, en, lvl));
        @(posedge CLK);
        #1;
        exp = exp_q.pop_front();
        check(scen, {press, release_pulse, long_press, repeat_pulse, held}, exp);
    endtask

    task automatic run(input logic rst_n, input logic en, input logic lvl, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(rst_n, en, lvl);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        in      = 1'b0;
        @(posedge CLK);
        #1;

        scen = "reset";
        run(1'b0, 1'b1, 1'b0, 2);
        scen = "idle_low";
        run(1'b1, 1'b1, 1'b0, 20);

        scen = "short_press";
        run(1'b1, 1'b1, 1'b1, 3);
        run(1'b1, 1'b1, 1'b0, 4);

        scen = "long_repeat";
        run(1'b1, 1'b1, 1'b1, 30);
        run(1'b1, 1'b1, 1'b0, 4);

        scen = "release_beats_long";
        run(1'b1, 1'b1, 1'b1, LONG_COUNT);
        run(1'b1, 1'b1, 1'b0, 3);

`ifdef BUTTON_EVENT_REPEAT_EN
        scen = "release_beats_repeat";
        run(1'b1, 1'b1, 1'b1, LONG_COUNT + REPEAT_PERIOD);
        run(1'b1, 1'b1, 1'b0, 3);
`endif

        scen = "enable_while_held";
        run(1'b1, 1'b0, 1'b1, 5);
        run(1'b1, 1'b1, 1'b1, 6);
        run(1'b1, 1'b1, 1'b0, 2);
        run(1'b1, 1'b1, 1'b1, 4);
        run(1'b1, 1'b1, 1'b0, 3);

        scen = "disable_mid_press";
        run(1'b1, 1'b1, 1'b1, 4);
        run(1'b1, 1'b0, 1'b1, 3);
        run(1'b1, 1'b1, 1'b1, 3);
        run(1'b1, 1'b1, 1'b0, 2);

        scen = "reset_mid_hold";
        run(1'b1, 1'b1, 1'b1, LONG_COUNT + 2 * REPEAT_PERIOD + 2);
        run(1'b0, 1'b1, 1'b1, 1);
        run(1'b1, 1'b1, 1'b1, 5);
        run(1'b1, 1'b1, 1'b0, 3);

        scen = "random";
        for (int unsigned i = 0; i < 300; i++) begin
            step((i % 97) != 96, (i % 61) < 55, $urandom_range(0, 7) != 0 ? in : ~in);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
